mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit in the Execute stage; sole writer of the HI/LO register pair that the ALU reads for mfhi/mflo. Accepts mult/multu/div/divu as multi-cycle operations with a start/busy handshake, and mthi/mtlo as single-cycle writes. Outputs `hi`/`lo` feed the ALU `hi`/`lo` inputs directly. `busy` feeds the hazard unit.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `A`  in  32: rs operand (forwarded value).
- `B`  in  32: rt operand (forwarded value).
- `MDUOp`  in  3: operation code. 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; 111 is treated as none.
- `start`  in  1: one-cycle strobe, qualifies `MDUOp` 001–100 in E stage.
- `busy`  out  1: multi-cycle operation in progress.
- `hi`  out  32: architectural HI.
- `lo`  out  32: architectural LO.

## Operation
- FSM states:
  - IDLE → BUSY on a rising edge with `start`=1 and `MDUOp` in 001–100.
  - BUSY → IDLE when the counter reaches 1.
- On the start edge:
  - Latch the operation result into internal `hi_pend`/`lo_pend`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
- mult: {hi,lo} = $signed(A)*$signed(B), 64-bit product.
- multu: {hi,lo} = A*B, unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: lo = A/B, hi = A%B, both unsigned.
- Divide by zero (B==0): operation still takes `DIV_CYCLES` with busy; hi/lo are left unchanged at commit.
- mthi/mtlo: when `busy`=0, `hi`←A (or `lo`←A) at the next edge; `start` is not required.
- Any `start` or mthi/mtlo while `busy`=1 is ignored.
  - The hazard unit stalls all MD instructions (including mfhi/mflo) while `start|busy`, so this never occurs legally.
- `start` with `MDUOp` 000/101–111 is ignored by the FSM; 101/110 still perform their write.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0; FSM=IDLE; counter=0; pending registers=0.
- Start sampled at edge T0:
  - `busy`=1 from just after T0 through the edge at T0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - `hi`/`lo` take the result at edge T0+N, the same edge that drops `busy`.
  - An mfhi issued after `busy` falls reads the new value; there is no bypass.
- `start` may arrive in the cycle right after `busy` falls; it launches a new operation with no bubble.
- mthi/mtlo write latency is 1 edge; the result is visible in the following cycle.
- Reset asserted mid-operation: `busy`, `hi`, `lo` go to 0 immediately (async), and the pending result is discarded.
- `A`/`B` are sampled only on the start edge; later changes during BUSY have no effect.

## Structure
- Shared header (`define` include) holds:
  - MDUOp encodings, reused by the controller decode.
  - Default cycle counts.
- No sub-module: a single module with FSM, down-counter, pending registers and HI/LO registers.
- The 64-bit product and div/mod are behavioural operators, computed once at start and held in the pending registers.

## Test plan
- Reset then idle → `busy`=0, `hi`=`lo`=0.
- mult, A=0xFFFFFFFE (−2), B=3, start at T0:
  - `busy` high for cycles T0+1..T0+5.
  - At edge T0+5: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- multu with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA after 5 cycles.
- div, A=−7 (0xFFFFFFF9), B=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- divu with B=0 after mthi 0x1234, mtlo 0x5678:
  - `busy` high for 10 cycles.
  - Afterwards `hi`=0x1234, `lo`=0x5678.
- Reset pulsed 3 cycles into a div → `busy`=0, `hi`=`lo`=0 immediately, and no late commit.
- mtlo during BUSY → ignored; a back-to-back start the cycle after `busy` falls completes correctly.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings (also used
// by the controller decode) and default operation latencies.
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  // True for the four ops that launch a multi-cycle operation.
  function automatic logic is_md_launch(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: owns architectural HI/LO. The result is computed once
// at the start edge, parked in pending registers, and committed when the
// latency counter expires so software sees the documented multi-cycle timing.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 16;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_pend, lo_pend;
  logic             pend_we;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_sdiv, b_udiv;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;
  logic               launch;

  // Divisor is forced to 1 for B==0 (result discarded anyway) and for the
  // 0x80000000 / -1 overflow case, where dividing by 1 yields the required
  // quotient 0x80000000 and remainder 0 without an undefined operation.
  assign b_udiv = (B == 32'd0) ? 32'd1 : B;
  assign b_sdiv = ((B == 32'd0) || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF))
                  ? 32'd1 : B;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign quot_s = $signed(A) / $signed(b_sdiv);
  assign rem_s  = $signed(A) % $signed(b_sdiv);
  assign quot_u = A / b_udiv;
  assign rem_u  = A % b_udiv;

  assign launch = start && is_md_launch(MDUOp);
  assign busy   = (state == ST_BUSY);

  // Select the result to park; divide by zero parks nothing (commit disabled).
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    case (MDUOp)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_hi = rem_s;
        res_lo = quot_s;
        res_we = (B != 32'd0);
      end
      MDU_DIVU: begin
        res_hi = rem_u;
        res_lo = quot_u;
        res_we = (B != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  // FSM, latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
      pend_we <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == ST_BUSY) begin
      // All new requests are ignored while busy.
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state <= ST_IDLE;
        if (pend_we) begin
          hi <= hi_pend;
          lo <= lo_pend;
        end
      end
    end else if (launch) begin
      state   <= ST_BUSY;
      cnt     <= (MDUOp == MDU_MULT || MDUOp == MDU_MULTU)
                 ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      hi_pend <= res_hi;
      lo_pend <= res_lo;
      pend_we <= res_we;
    end else if (MDUOp == MDU_MTHI) begin
      hi <= A;
    end else if (MDUOp == MDU_MTLO) begin
      lo <= A;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of multi-cycle ops with
// preloaded HI/LO, plus hand sequences for reset and busy-time corner cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    MDUOp = op; A = v; start = 1'b0;
    step();
    MDUOp = 3'b000;
  endtask

  // Launch op, then count cycles with busy high (bounded). Returns the
  // hi/lo seen in the last busy cycle, i.e. just before the commit edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output logic [31:0] last_hi, output logic [31:0] last_lo);
    MDUOp = op; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; MDUOp = 3'b000; A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
    nbusy = 0; last_hi = hi; last_lo = lo;
    while (busy === 1'b1 && nbusy < 60) begin
      nbusy++;
      last_hi = hi; last_lo = lo;
      step();
    end
  endtask

  initial begin
    int nb;
    logic [31:0] lh, ll;

    vecs[0] = '{"mult_neg",   3'b001, 32'hFFFF_FFFE, 32'd3,          32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu",      3'b010, 32'hFFFF_FFFE, 32'd3,          32'h1, 32'h2, 32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{"div_neg",    3'b011, 32'hFFFF_FFF9, 32'd2,          32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu",       3'b100, 32'hFFFF_FFF9, 32'd2,          32'h1, 32'h2, 32'h0000_0001, 32'h7FFF_FFFC, 10};
    vecs[4] = '{"div_ovf",    3'b011, 32'h8000_0000, 32'hFFFF_FFFF,  32'h1, 32'h2, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5] = '{"divu_zero",  3'b100, 32'd77,        32'd0,          32'h1234, 32'h5678, 32'h1234, 32'h5678, 10};
    vecs[6] = '{"div_zero",   3'b011, 32'hFFFF_FF00, 32'd0,          32'hCAFE, 32'hBEEF, 32'hCAFE, 32'hBEEF, 10};
    vecs[7] = '{"mult_max",   3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h1, 32'h2, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[8] = '{"div_negdiv", 3'b011, 32'd7,         32'hFFFF_FFFE,  32'h1, 32'h2, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[9] = '{"multu_max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h1, 32'h2, 32'hFFFF_FFFE, 32'h0000_0001, 5};

    reset = 1'b1; A = '0; B = '0; MDUOp = 3'b000; start = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // start with a non-launch op must not start the FSM
    MDUOp = 3'b000; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_none_busy", {31'd0, busy}, 32'd0);

    // mthi accompanied by start still writes
    MDUOp = 3'b101; A = 32'h0BAD_F00D; start = 1'b1;
    step();
    start = 1'b0; MDUOp = 3'b000;
    chk("mthi_with_start", hi, 32'h0BAD_F00D);

    for (int i = 0; i < 10; i++) begin
      mt(3'b101, vecs[i].pre_hi);
      mt(3'b110, vecs[i].pre_lo);
      chk({vecs[i].name, "_prehi"}, hi, vecs[i].pre_hi);
      chk({vecs[i].name, "_prelo"}, lo, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, lh, ll);
      chk({vecs[i].name, "_busy_cycles"}, nb, vecs[i].cyc);
      chk({vecs[i].name, "_hi_held"}, lh, vecs[i].pre_hi);
      chk({vecs[i].name, "_lo_held"}, ll, vecs[i].pre_lo);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // Reset 3 cycles into a div: immediate clear, no late commit.
    MDUOp = 3'b011; A = 32'd100; B = 32'd7; start = 1'b1;
    step();
    start = 1'b0; MDUOp = 3'b000;
    step(); step(); step();
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #2 reset = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("rst_nolate_busy", {31'd0, busy}, 32'd0);
    chk("rst_nolate_hi", hi, 32'd0);
    chk("rst_nolate_lo", lo, 32'd0);

    // mtlo/mthi during busy are ignored (use div by zero so nothing commits).
    mt(3'b110, 32'h5678);
    MDUOp = 3'b100; A = 32'd9; B = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    MDUOp = 3'b110; A = 32'hDEAD_0001;
    step();
    MDUOp = 3'b101; A = 32'hDEAD_0002;
    step();
    MDUOp = 3'b001; A = 32'd4; B = 32'd4; start = 1'b1;
    step();
    MDUOp = 3'b000; start = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h5678);
    chk("mthi_busy_hi", hi, 32'd0);
    nb = 3;
    while (busy === 1'b1 && nb < 60) begin nb++; step(); end
    chk("ignored_busy_cycles", nb, 32'd10);
    chk("ignored_final_lo", lo, 32'h5678);
    chk("ignored_final_hi", hi, 32'd0);

    // Back-to-back: second start in the cycle right after busy falls.
    run_op(3'b010, 32'd6, 32'd7, nb, lh, ll);
    chk("b2b_first_cycles", nb, 32'd5);
    chk("b2b_first_lo", lo, 32'd42);
    run_op(3'b100, 32'd100, 32'd7, nb, lh, ll);
    chk("b2b_second_cycles", nb, 32'd10);
    chk("b2b_second_held_lo", ll, 32'd42);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_second_lo", lo, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
